uart_rx_cfg: RTL

//  Parametrised UART receiver; successor to the fixed 8N1 receiver. Deserialises an async
//  rx line using an oversampling baud tick, with configurable data width, parity and stop

---
 rtl/uart_rx_cfg.sv | 192 +++++++++++++++++++
 1 files changed

// File: rtl/uart_rx_cfg.sv
`default_nettype none
// ============================================================================
// Module      : uart_rx_cfg
// Description : Parametrised UART receiver. Oversampled with an external
//               baud tick. Data width, parity and stop-bit count are set by
//               parameters. Includes an input synchroniser, start-glitch
//               rejection, parity and framing error flags, and break recovery.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_rx_cfg #(
    parameter int DATA_BITS  = 8,
    parameter int OVERSAMPLE = 16,
    parameter int PARITY_EN  = 0,
    parameter int PARITY_ODD = 0,
    parameter int STOP_BITS  = 1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 rx,
    input  logic                 br_tick,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_done,
    output logic                 parity_err,
    output logic                 frame_err,
    output logic                 busy
);

    localparam int c_TW = $clog2(OVERSAMPLE);
    localparam int c_BW = $clog2(DATA_BITS + 1);

    localparam logic [c_TW-1:0] c_TICK_MID  = c_TW'(OVERSAMPLE / 2 - 1);
    localparam logic [c_TW-1:0] c_TICK_END  = c_TW'(OVERSAMPLE - 1);
    localparam logic [c_BW-1:0] c_LAST_DATA = c_BW'(DATA_BITS - 1);
    localparam logic [c_BW-1:0] c_LAST_STOP = c_BW'(STOP_BITS - 1);
    localparam logic            c_PAR_EN    = (PARITY_EN != 0);
    localparam logic            c_ODD       = (PARITY_ODD != 0);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
        S_PARITY = 3'd3,
        S_STOP   = 3'd4,
        S_BREAK  = 3'd5
    } state_t;

    logic [1:0]           r_sync;
    state_t               r_state;
    logic [c_TW-1:0]      r_tick_cnt;
    logic [c_BW-1:0]      r_bit_cnt;
    logic [DATA_BITS-1:0] r_shreg;
    logic                 r_perr;
    logic                 r_ferr;
    logic                 r_fire;
    logic [DATA_BITS-1:0] r_rx_data;
    logic                 r_rx_done;
    logic                 r_parity_err;
    logic                 r_frame_err;

    logic w_rx;
    logic w_ferr_final;

    // Synchronised line and the frame error including the current stop sample
    assign w_rx         = r_sync[1];
    assign w_ferr_final = r_ferr | ~w_rx;

    // Two-flop synchroniser; resets to the idle (high) line level
    always_ff @(posedge clk) begin
        if (reset) begin
            r_sync <= 2'b11;
        end else begin
            r_sync <= {r_sync[0], rx};
        end
    end

    // Frame state machine; completes at the last stop-bit centre so a
    // back-to-back start edge is seen, and hands the result to the output stage
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= S_IDLE;
            r_tick_cnt <= '0;
            r_bit_cnt  <= '0;
            r_shreg    <= '0;
            r_perr     <= 1'b0;
            r_ferr     <= 1'b0;
            r_fire     <= 1'b0;
        end else begin
            r_fire <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (!w_rx) begin
                        r_state    <= S_START;
                        r_tick_cnt <= '0;
                        r_bit_cnt  <= '0;
                        r_perr     <= 1'b0;
                        r_ferr     <= 1'b0;
                    end
                end
                S_START: begin
                    if (br_tick) begin
                        if (r_tick_cnt == c_TICK_MID) begin
                            r_tick_cnt <= '0;
                            // A high line at mid-start is a glitch: drop silently
                            r_state    <= w_rx ? S_IDLE : S_DATA;
                        end else begin
                            r_tick_cnt <= r_tick_cnt + 1'b1;
                        end
                    end
                end
                S_DATA: begin
                    if (br_tick) begin
                        if (r_tick_cnt == c_TICK_END) begin
                            r_tick_cnt <= '0;
                            r_shreg    <= {w_rx, r_shreg[DATA_BITS-1:1]};
                            if (r_bit_cnt == c_LAST_DATA) begin
                                r_bit_cnt <= '0;
                                r_state   <= c_PAR_EN ? S_PARITY : S_STOP;
                            end else begin
                                r_bit_cnt <= r_bit_cnt + 1'b1;
                            end
                        end else begin
                            r_tick_cnt <= r_tick_cnt + 1'b1;
                        end
                    end
                end
                S_PARITY: begin
                    if (br_tick) begin
                        if (r_tick_cnt == c_TICK_END) begin
                            r_tick_cnt <= '0;
                            r_perr     <= ((^r_shreg) ^ w_rx) != c_ODD;
                            r_state    <= S_STOP;
                        end else begin
                            r_tick_cnt <= r_tick_cnt + 1'b1;
                        end
                    end
                end
                S_STOP: begin
                    if (br_tick) begin
                        if (r_tick_cnt == c_TICK_END) begin
                            r_tick_cnt <= '0;
                            r_ferr     <= w_ferr_final;
                            if (r_bit_cnt == c_LAST_STOP) begin
                                r_bit_cnt <= '0;
                                r_fire    <= 1'b1;
                                r_state   <= w_ferr_final ? S_BREAK : S_IDLE;
                            end else begin
                                r_bit_cnt <= r_bit_cnt + 1'b1;
                            end
                        end else begin
                            r_tick_cnt <= r_tick_cnt + 1'b1;
                        end
                    end
                end
                S_BREAK: begin
                    // A held-low line must return high before a new frame
                    if (w_rx) begin
                        r_state <= S_IDLE;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    // Output stage: word and flags update together with the one-cycle done pulse
    always_ff @(posedge clk) begin
        if (reset) begin
            r_rx_data    <= '0;
            r_rx_done    <= 1'b0;
            r_parity_err <= 1'b0;
            r_frame_err  <= 1'b0;
        end else begin
            r_rx_done <= 1'b0;
            if (r_fire) begin
                r_rx_data    <= r_shreg;
                r_parity_err <= r_perr;
                r_frame_err  <= r_ferr;
                r_rx_done    <= 1'b1;
            end
        end
    end

    assign rx_data    = r_rx_data;
    assign rx_done    = r_rx_done;
    assign parity_err = r_parity_err;
    assign frame_err  = r_frame_err;
    assign busy       = (r_state != S_IDLE);

endmodule
`default_nettype wire
